// File: rtl/bus_master_port_if.sv
// Bundle of the core-side request/response signals and the bit-serial bus
// signals of one bus_master_port.
//   master : the view taken by bus_master_port itself
//   slave  : the opposite view, used by whatever drives the master
//            (core model plus bus slave model)
interface bus_master_port_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  // Core request side
  logic              req_valid;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  // Core response side
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  // Serial bus towards the slave port
  logic              validOut;
  logic              wren;
  logic              AddressOut;
  logic              DataOut;
  // Serial bus from the slave port
  logic              readyIn;
  logic              validIn;
  logic              DataIn;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata,
    input  readyIn, validIn, DataIn,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output validOut, wren, AddressOut, DataOut
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata,
    output readyIn, validIn, DataIn,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  validOut, wren, AddressOut, DataOut
  );
endinterface

// File: rtl/bus_master_port.sv
// bus_master_port: serial-bus initiator. Takes one parallel read/write
// request from the core, sends a header cycle then the address MSB first
// (write data rides on DataOut, LSB-aligned with the address), waits for the
// slave's completion, deserialises read data and gives a one-cycle response.
// DATA_W must not exceed ADDR_W.
//
// Optional feature: define BUS_MASTER_TIMEOUT_EN to abort a wait state after
// TIMEOUT cycles without completion (resp_err=1). Without it the wait states
// block indefinitely and resp_err is tied low.
module bus_master_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8
`ifdef BUS_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input logic               clk,
  input logic               rstn,
  bus_master_port_if.master bus
);

  localparam int ACNT_W = $clog2(ADDR_W + 1);
  localparam int RCNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, HDR, ADDR, WR_WAIT, RD_WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_sr_q, addr_sr_d;   // address, shifted out MSB first
  logic [ADDR_W-1:0]   wdata_sr_q, wdata_sr_d; // write data zero-extended to ADDR_W
  logic [ACNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;       // read data being assembled
  logic [RCNT_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;       // last completed read, held
  logic [DATA_W-1:0]   rx_next;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                err_q, err_d;
`endif

  assign rx_next = (rx_sr_q << 1) | DATA_W'(bus.DataIn);

  // Next-state and datapath updates for the transaction sequencer
  always_comb begin
    // NOTE: every signal gets its hold value first so no path infers a latch.
    state_d    = state_q;
    wr_d       = wr_q;
    addr_sr_d  = addr_sr_q;
    wdata_sr_d = wdata_sr_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    rx_cnt_d   = rx_cnt_q;
    rdata_d    = rdata_q;
`ifdef BUS_MASTER_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d       = bus.req_wr;
          addr_sr_d  = bus.req_addr;
          wdata_sr_d = ADDR_W'(bus.req_wdata);
          bit_cnt_d  = '0;
          state_d    = HDR;
        end
      end
      HDR: state_d = ADDR;
      ADDR: begin
        addr_sr_d  = addr_sr_q << 1;
        wdata_sr_d = wdata_sr_q << 1;
        bit_cnt_d  = bit_cnt_q + ACNT_W'(1);
        if (bit_cnt_q == ACNT_W'(ADDR_W - 1)) begin
          state_d  = wr_q ? WR_WAIT : RD_WAIT;
          rx_cnt_d = '0;
`ifdef BUS_MASTER_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      WR_WAIT: begin
        if (bus.readyIn) begin
          state_d = RESP;
`ifdef BUS_MASTER_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        end
      end
      RD_WAIT: begin
        if (bus.validIn) begin
          rx_sr_d  = rx_next;
          rx_cnt_d = rx_cnt_q + RCNT_W'(1);
`ifdef BUS_MASTER_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          if (rx_cnt_q == RCNT_W'(DATA_W - 1)) begin
            rdata_d = rx_next;
            state_d = RESP;
`ifdef BUS_MASTER_TIMEOUT_EN
            err_d   = 1'b0;
`endif
          end
`ifdef BUS_MASTER_TIMEOUT_EN
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          // Abort: resp_rdata keeps the previous read result
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      addr_sr_q  <= '0;
      wdata_sr_q <= '0;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      rx_cnt_q   <= '0;
      rdata_q    <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_sr_q  <= addr_sr_d;
      wdata_sr_q <= wdata_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_cnt_q   <= rx_cnt_d;
      rdata_q    <= rdata_d;
`ifdef BUS_MASTER_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  // Moore outputs decoded from the registered state
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.validOut   = (state_q == HDR) || (state_q == ADDR);
  assign bus.wren       = bus.validOut && wr_q;
  assign bus.AddressOut = (state_q == ADDR) && addr_sr_q[ADDR_W-1];
  assign bus.DataOut    = (state_q == ADDR) && wr_q && wdata_sr_q[ADDR_W-1];
`ifdef BUS_MASTER_TIMEOUT_EN
  assign bus.resp_err   = (state_q == RESP) && err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: a table of read/write transactions applied in a
// loop, plus hand-written sequences for back-to-back requests, reset in the
// middle of the address phase and (when built with BUS_MASTER_TIMEOUT_EN)
// the wait-state timeout. Responses are checked through a scoreboard queue.
module tb_bus_master_port;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  logic clk;
  logic rstn;

  bus_master_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bus_master_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
`ifdef BUS_MASTER_TIMEOUT_EN
    , .TIMEOUT(20)
`endif
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } exp_t;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rbits;      // read bits the slave sends, MSB first
    int                gap_pos;    // idle cycles inserted before this bit
    int                gap_len;
    int                ready_dly;  // wait cycles before readyIn pulse
    logic [DATA_W-1:0] exp_rdata;  // required resp_rdata for reads
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  exp_t sb_q [$];
  int   n_checks = 0;
  int   errors   = 0;
  logic [DATA_W-1:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every resp_valid pulse must match the oldest entry
  always @(negedge clk) begin
    if (rstn && bus.resp_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        errors++;
        $display("FAIL spurious_resp: resp_valid with empty scoreboard at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_err", bus.resp_err, e.err);
      end
    end
  end

  // Presents a request in the IDLE cycle; returns in the HDR cycle
  task automatic accept(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata,
                        input logic [DATA_W-1:0] exp_rd, input logic exp_err);
    exp_t e;
    check("idle_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    step();
    bus.req_valid = 1'b0;
    bus.req_addr  = ~addr;     // request fields must already be latched
    bus.req_wdata = ~wdata;
  endtask

  // Checks HDR and ADDR cycles; returns in the first wait-state cycle
  task automatic check_frame(input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata);
    check("hdr_valid", bus.validOut, 1);
    check("hdr_wren", bus.wren, wr);
    check("hdr_addr", bus.AddressOut, 0);
    check("hdr_data", bus.DataOut, 0);
    check("busy_ready", bus.req_ready, 0);
    for (int k = 0; k < ADDR_W; k++) begin
      logic exp_d;
      step();
      exp_d = 1'b0;
      if (wr && k >= ADDR_W - DATA_W) exp_d = wdata[ADDR_W-1-k];
      check("addr_valid", bus.validOut, 1);
      check("addr_wren", bus.wren, wr);
      check("addr_bit", bus.AddressOut, addr[ADDR_W-1-k]);
      check("data_bit", bus.DataOut, exp_d);
    end
    step();
    check("wait_valid", bus.validOut, 0);
    check("wait_wren", bus.wren, 0);
    check("wait_addr", bus.AddressOut, 0);
    check("wait_data", bus.DataOut, 0);
  endtask

  // From the first WR_WAIT cycle: pulse readyIn after dly cycles; returns in IDLE
  task automatic finish_write(input int dly);
    for (int d = 0; d < dly; d++) begin
      check("wr_wait_no_resp", bus.resp_valid, 0);
      step();
    end
    bus.readyIn = 1'b1;
    step();
    bus.readyIn = 1'b0;
    check("wr_resp_valid", bus.resp_valid, 1);
    step();
    check("wr_resp_pulse", bus.resp_valid, 0);
    check("wr_back_idle", bus.req_ready, 1);
  endtask

  // From the first RD_WAIT cycle: deliver bits with an optional gap; returns in IDLE
  task automatic finish_read(input logic [DATA_W-1:0] bits, input int gap_pos, input int gap_len);
    for (int i = 0; i < DATA_W; i++) begin
      if (i == gap_pos) begin
        bus.validIn = 1'b0;
        bus.DataIn  = ~bits[DATA_W-1-i];   // junk while not qualified
        for (int g = 0; g < gap_len; g++) begin
          check("rd_gap_no_resp", bus.resp_valid, 0);
          step();
        end
      end
      bus.validIn = 1'b1;
      bus.DataIn  = bits[DATA_W-1-i];
      check("rd_wait_no_resp", bus.resp_valid, 0);
      check("rd_wren", bus.wren, 0);
      step();
    end
    bus.validIn = 1'b0;
    bus.DataIn  = 1'b0;
    check("rd_resp_valid", bus.resp_valid, 1);
    step();
    check("rd_resp_pulse", bus.resp_valid, 0);
    check("rd_back_idle", bus.req_ready, 1);
  endtask

  initial begin
    vecs[0] = '{wr:1'b1, addr:12'h12B, wdata:8'hA5, rbits:8'h00, gap_pos:0, gap_len:0, ready_dly:5, exp_rdata:8'h00};
    vecs[1] = '{wr:1'b0, addr:12'h0A5, wdata:8'hFF, rbits:8'hCA, gap_pos:0, gap_len:0, ready_dly:0, exp_rdata:8'hCA};
    vecs[2] = '{wr:1'b0, addr:12'h3F0, wdata:8'h00, rbits:8'hCA, gap_pos:3, gap_len:2, ready_dly:0, exp_rdata:8'hCA};
    vecs[3] = '{wr:1'b1, addr:12'hFFF, wdata:8'h00, rbits:8'h00, gap_pos:0, gap_len:0, ready_dly:0, exp_rdata:8'h00};
    vecs[4] = '{wr:1'b1, addr:12'h000, wdata:8'hFF, rbits:8'h00, gap_pos:0, gap_len:0, ready_dly:2, exp_rdata:8'h00};
    vecs[5] = '{wr:1'b0, addr:12'h800, wdata:8'hAA, rbits:8'h01, gap_pos:0, gap_len:1, ready_dly:0, exp_rdata:8'h01};
    vecs[6] = '{wr:1'b0, addr:12'h001, wdata:8'h55, rbits:8'hFF, gap_pos:7, gap_len:3, ready_dly:0, exp_rdata:8'hFF};

    rstn          = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.readyIn   = 1'b0;
    bus.validIn   = 1'b0;
    bus.DataIn    = 1'b0;

    // Reset state, with slave inputs active to show they are ignored in IDLE
    step();
    bus.readyIn = 1'b1;
    bus.validIn = 1'b1;
    step();
    check("rst_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_rdata", bus.resp_rdata, 0);
    check("rst_err", bus.resp_err, 0);
    check("rst_validOut", bus.validOut, 0);
    check("rst_wren", bus.wren, 0);
    check("rst_addr", bus.AddressOut, 0);
    check("rst_data", bus.DataOut, 0);
    rstn = 1'b1;
    step();
    step();
    check("idle_ignores_slave", bus.validOut, 0);
    bus.readyIn = 1'b0;
    bus.validIn = 1'b0;

    // Table-driven transactions
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        accept(1'b1, vecs[i].addr, vecs[i].wdata, last_rd, 1'b0);
        check_frame(1'b1, vecs[i].addr, vecs[i].wdata);
        finish_write(vecs[i].ready_dly);
      end else begin
        accept(1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0);
        check_frame(1'b0, vecs[i].addr, vecs[i].wdata);
        finish_read(vecs[i].rbits, vecs[i].gap_pos, vecs[i].gap_len);
        last_rd = vecs[i].exp_rdata;
      end
      step();
    end

    // Back-to-back writes with req_valid held high throughout the first
    check("b2b_ready", bus.req_ready, 1);
    begin
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b1;
      bus.req_addr  = 12'h5A3;
      bus.req_wdata = 8'h3C;
      e.rdata = last_rd;
      e.err   = 1'b0;
      sb_q.push_back(e);
      step();
      // Second request presented while busy; it must not disturb the first
      bus.req_addr  = 12'h0C6;
      bus.req_wdata = 8'hE7;
      sb_q.push_back(e);
      check_frame(1'b1, 12'h5A3, 8'h3C);
      finish_write(0);
      step();
      bus.req_valid = 1'b0;
      check_frame(1'b1, 12'h0C6, 8'hE7);
      finish_write(1);
      for (int i = 0; i < 3; i++) begin
        step();
        check("b2b_no_third", bus.validOut, 0);
      end
    end

    // Reset asserted during address bit 5 of a write
    accept(1'b1, 12'h7E1, 8'h5A, last_rd, 1'b0);
    for (int i = 0; i < 6; i++) step();
    check("pre_rst_validOut", bus.validOut, 1);
    check("pre_rst_addr_bit5", bus.AddressOut, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_validOut", bus.validOut, 0);
    check("mid_rst_wren", bus.wren, 0);
    check("mid_rst_addr", bus.AddressOut, 0);
    check("mid_rst_data", bus.DataOut, 0);
    check("mid_rst_ready", bus.req_ready, 1);
    check("mid_rst_rdata", bus.resp_rdata, 0);
    void'(sb_q.pop_back());
    last_rd = '0;
    step();
    step();
    rstn = 1'b1;
    step();
    check("post_rst_ready", bus.req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_no_resp", bus.resp_valid, 0);
      step();
    end

    // Transaction after reset still works
    accept(1'b0, 12'h2C3, 8'h00, 8'h96, 1'b0);
    check_frame(1'b0, 12'h2C3, 8'h00);
    finish_read(8'h96, 4, 1);
    last_rd = 8'h96;
    step();

`ifdef BUS_MASTER_TIMEOUT_EN
    // Read with no validIn: abort exactly 20 cycles after entering RD_WAIT
    accept(1'b0, 12'h2A5, 8'h00, last_rd, 1'b1);
    check_frame(1'b0, 12'h2A5, 8'h00);
    for (int i = 0; i < 20; i++) begin
      check("to_no_resp", bus.resp_valid, 0);
      step();
    end
    check("to_resp_valid", bus.resp_valid, 1);
    check("to_resp_err", bus.resp_err, 1);
    check("to_rdata_kept", bus.resp_rdata, last_rd);
    step();
    check("to_back_idle", bus.req_ready, 1);
    check("to_err_cleared", bus.resp_err, 0);
    step();
`endif

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

endmodule
